// File: rtl/booth_mul_pkg.sv
// Shared types for the Booth multiplier arbiter: FSM states, Booth op decode,
// and the width of the optional performance counters.
package booth_mul_pkg;

    typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

    typedef enum logic [1:0] {OP_NOP, OP_ADD, OP_SUB} booth_op_t;

    localparam int unsigned PERF_W = 16;

    function automatic booth_op_t booth_decode(input logic q0, input logic q_1);
        case ({q0, q_1})
            2'b10:   return OP_SUB;
            2'b01:   return OP_ADD;
            default: return OP_NOP;
        endcase
    endfunction

endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth iteration: conditional add/subtract of M into A, then an
// arithmetic right shift of {A, Q, Q_1}.
module booth_step
    import booth_mul_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [N:0]   a,
    input  logic [N-1:0] q,
    input  logic         q_1,
    input  logic [N:0]   m,
    output logic [N:0]   a_next,
    output logic [N-1:0] q_next,
    output logic         q_1_next
);

    logic [N:0] sum;

    always_comb begin
        case (booth_decode(q[0], q_1))
            OP_ADD:  sum = a + m;
            OP_SUB:  sum = a - m;
            default: sum = a;
        endcase
        a_next   = {sum[N], sum[N:1]};
        q_next   = {sum[0], q[N-1:1]};
        q_1_next = q[0];
    end

endmodule

// File: rtl/booth_mul_arbiter.sv
// Round-robin arbiter sharing one sequential Booth multiplier among NREQ clients.
// Optional BOOTH_MUL_ARB_PERF_EN adds per-requester completion and stall counters.
module booth_mul_arbiter
    import booth_mul_pkg::*;
#(
    parameter int N    = 8,
    parameter int NREQ = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req_valid,
    output logic [NREQ-1:0]           req_ready,
    input  logic [NREQ*N-1:0]         req_m,
    input  logic [NREQ*N-1:0]         req_q,
    output logic                      resp_valid,
    input  logic                      resp_ready,
    output logic [$clog2(NREQ)-1:0]   resp_id,
    output logic [2*N-1:0]            resp_p,
    output logic                      busy
`ifdef BOOTH_MUL_ARB_PERF_EN
    ,
    output logic [NREQ*PERF_W-1:0]    perf_ops,
    output logic [PERF_W-1:0]         perf_stall
`endif
);

    localparam int IDW = $clog2(NREQ);
    localparam int CW  = $clog2(N);

    state_t state, state_next;

    logic [IDW-1:0] rr_ptr, id_reg, grant_id, idx;
    logic           grant_found, take;
    logic [N:0]     a_reg, m_reg, a_step;
    logic [N-1:0]   q_reg, q_step, m_sel, q_sel;
    logic           q_1, q_1_step;
    logic [CW-1:0]  cnt;

    // First pending requester at or above rr_ptr, wrapping modulo NREQ.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        idx         = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = IDW'((32'(rr_ptr) + k) % NREQ);
            if (!grant_found && req_valid[idx]) begin
                grant_found = 1'b1;
                grant_id    = idx;
            end
        end
    end

    assign take  = (state == IDLE) && grant_found && !rst;
    assign m_sel = req_m[int'(grant_id)*N +: N];
    assign q_sel = req_q[int'(grant_id)*N +: N];

    booth_step #(.N(N)) u_step (
        .a        (a_reg),
        .q        (q_reg),
        .q_1      (q_1),
        .m        (m_reg),
        .a_next   (a_step),
        .q_next   (q_step),
        .q_1_next (q_1_step)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (take) state_next = ITER;
            ITER:    if (cnt == CW'(N-1)) state_next = DONE;
            DONE:    if (resp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        req_ready = '0;
        if (take) req_ready[grant_id] = 1'b1;
        resp_valid = (state == DONE);
        busy       = (state != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg  <= '0;
            m_reg  <= '0;
            q_reg  <= '0;
            q_1    <= 1'b0;
            cnt    <= '0;
            id_reg <= '0;
            rr_ptr <= '0;
        end else begin
            case (state)
                IDLE: if (take) begin
                    a_reg  <= '0;
                    q_reg  <= q_sel;
                    q_1    <= 1'b0;
                    m_reg  <= {m_sel[N-1], m_sel};
                    cnt    <= '0;
                    id_reg <= grant_id;
                    rr_ptr <= (grant_id == IDW'(NREQ-1)) ? '0 : grant_id + 1'b1;
                end
                ITER: begin
                    a_reg <= a_step;
                    q_reg <= q_step;
                    q_1   <= q_1_step;
                    cnt   <= cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // A[N] is only a guard bit; after N steps the product fits in 2N bits.
    assign resp_p  = {a_reg[N-1:0], q_reg};
    assign resp_id = id_reg;

`ifdef BOOTH_MUL_ARB_PERF_EN
    logic [PERF_W-1:0] ops_cnt [NREQ];
    logic [PERF_W-1:0] stall_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned k = 0; k < NREQ; k++) ops_cnt[k] <= '0;
            stall_cnt <= '0;
        end else begin
            if (resp_valid && resp_ready && ops_cnt[id_reg] != '1)
                ops_cnt[id_reg] <= ops_cnt[id_reg] + 1'b1;
            if (state == DONE && !resp_ready && stall_cnt != '1)
                stall_cnt <= stall_cnt + 1'b1;
        end
    end

    always_comb begin
        perf_ops = '0;
        for (int unsigned k = 0; k < NREQ; k++)
            perf_ops[k*PERF_W +: PERF_W] = ops_cnt[k];
    end

    assign perf_stall = stall_cnt;
`endif

endmodule
